zone_luma_stats: RTL and testbench

Per-zone luminance statistics collector for the dynamic backlight path. Sits directly downstream of the vertical zone-address stage: consumes the 4-bit zone address (0–14 active, 15 = outside active area) with the pixel stream, and accumulates per-zone peak and sum of pixel max(R,G,B) over each frame. At each frame boundary it snapshots the 15 zone records and streams them to the backlight duty calculator over a valid/ready handshake.

---
 rtl/zone_stats_pkg.sv | 28 ++
 rtl/zone_readout.sv | 71 +++++++
 rtl/zone_luma_stats.sv | 124 ++++++++++++
 tb/tb_zone_luma_stats.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zone_stats_pkg.sv
// Shared constants, readout state type and saturating adder for zone_luma_stats.
// Latency: none. This file holds only declarations and a combinational helper.
// Backpressure: not applicable.
package zone_stats_pkg;

  localparam int         ZONES   = 15;    // vertical zones 0..14
  localparam int         DATA_W  = 8;     // colour component width
  localparam int         SUM_W   = 26;    // 72 lines x 1920 px x 255 fits
  localparam logic [3:0] NO_ZONE = 4'd15; // pixel outside the active area

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } rd_state_t;

  // Adds inc to acc and clamps at 2^width-1, so the result never wraps.
  // width must be 1..32; callers truncate the result to their own width.
  function automatic logic [31:0] sat_add(input logic [31:0] acc,
                                          input logic [31:0] inc,
                                          input int unsigned width);
    logic [32:0] total;
    logic [32:0] limit;
    total = {1'b0, acc} + {1'b0, inc};
    limit = (33'd1 << width) - 33'd1;
    return (total > limit) ? limit[31:0] : total[31:0];
  endfunction

endpackage

// File: rtl/zone_readout.sv
// Shadow bank plus readout FSM: streams the 15 frozen zone records in index order.
// Latency: first record is valid the cycle after start; one record per accepted cycle.
// Backpressure: valid/ready; a record and its index are held stable while ready is low.
//
// Ports: clk/rst_n (async active-low); start loads the shadow bank from
// peak_bank/sum_bank (honoured only in IDLE); valid/ready/index/peak/sum form the
// record stream; busy is high while records remain to be sent.
module zone_readout
  import zone_stats_pkg::*;
#(
  parameter int SUM_WIDTH = SUM_W
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [ZONES-1:0][DATA_W-1:0]        peak_bank,
  input  logic [ZONES-1:0][SUM_WIDTH-1:0]     sum_bank,
  input  logic                                ready,
  output logic                                valid,
  output logic [3:0]                          index,
  output logic [DATA_W-1:0]                   peak,
  output logic [SUM_WIDTH-1:0]                sum,
  output logic                                busy
);

  localparam logic [3:0] LAST_IDX = 4'(ZONES - 1);

  rd_state_t                         state;
  logic [3:0]                        idx;
  logic [ZONES-1:0][DATA_W-1:0]      shadow_peak;
  logic [ZONES-1:0][SUM_WIDTH-1:0]   shadow_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      shadow_peak <= '0;
      shadow_sum  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shadow_peak <= peak_bank;
            shadow_sum  <= sum_bank;
            idx         <= '0;
            state       <= SEND;
          end
        end
        SEND: begin
          if (ready) begin
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= IDLE;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
      endcase
    end
  end

  // Every output derives straight from registers; data is forced to zero
  // outside SEND so the idle bus does not carry a stale record.
  assign valid = (state == SEND);
  assign busy  = valid;
  assign index = idx;
  assign peak  = valid ? shadow_peak[idx] : '0;
  assign sum   = valid ? shadow_sum[idx]  : '0;

endmodule

// File: rtl/zone_luma_stats.sv
// Per-zone peak and saturating sum of max(R,G,B) per frame, streamed out at frame end.
// Latency: pixel to bank 2 clocks; VSYNC rise sampled at edge F gives first record at F+2.
// Backpressure: records wait on iZone_Ready; a frame ending mid-readout is dropped (oOverrun).
//
// Ports: iODCK pixel clock, iRST_N async active-low reset; iVSYNC (rising edge = frame
// end), iDE, iR/iG/iB, iV_Address (15 = no zone) form the pixel input; oZone_Valid,
// iZone_Ready, oZone_Index, oZone_Peak, oZone_Sum carry the records; oBusy flags a
// readout in progress; oOverrun pulses for one cycle when a frame result is dropped.
module zone_luma_stats
  import zone_stats_pkg::*;
#(
  // Sum width; must stay within 1..32 because of the 32-bit saturating adder.
  parameter int SUM_WIDTH = SUM_W
) (
  input  logic                   iODCK,
  input  logic                   iRST_N,
  input  logic                   iVSYNC,
  input  logic                   iDE,
  input  logic [DATA_W-1:0]      iR,
  input  logic [DATA_W-1:0]      iG,
  input  logic [DATA_W-1:0]      iB,
  input  logic [3:0]             iV_Address,
  output logic                   oZone_Valid,
  input  logic                   iZone_Ready,
  output logic [3:0]             oZone_Index,
  output logic [DATA_W-1:0]      oZone_Peak,
  output logic [SUM_WIDTH-1:0]   oZone_Sum,
  output logic                   oBusy,
  output logic                   oOverrun
);

  logic [DATA_W-1:0]                 lum;
  logic [DATA_W-1:0]                 p_lum;
  logic                              p_de;
  logic [3:0]                        p_zone;
  logic                              vs_cur;
  logic                              vs_prev;
  logic                              frame_end;
  logic                              frame_end_d;
  logic                              busy;
  logic                              copy;
  logic [ZONES-1:0]                  hit;
  logic [ZONES-1:0][DATA_W-1:0]      peak_bank;
  logic [ZONES-1:0][SUM_WIDTH-1:0]   sum_bank;
  logic [ZONES-1:0][DATA_W-1:0]      peak_next;
  logic [ZONES-1:0][SUM_WIDTH-1:0]   sum_next;

  always_comb begin
    lum = iR;
    if (iG > lum) lum = iG;
    if (iB > lum) lum = iB;
  end

  // Stage P and the frame-sync history share one register stage.
  always_ff @(posedge iODCK or negedge iRST_N) begin
    if (!iRST_N) begin
      p_lum       <= '0;
      p_de        <= 1'b0;
      p_zone      <= NO_ZONE;
      vs_cur      <= 1'b0;
      vs_prev     <= 1'b0;
      frame_end_d <= 1'b0;
    end else begin
      p_lum       <= lum;
      p_de        <= iDE;
      p_zone      <= iV_Address;
      vs_cur      <= iVSYNC;
      vs_prev     <= vs_cur;
      frame_end_d <= frame_end;
    end
  end

  // Cycle F: the pixel sitting in stage P still lands in the ending frame.
  // Cycle F+1: the bank is snapshotted (or dropped) and restarted from zero,
  // with that cycle's stage-P pixel counted toward the new frame.
  assign frame_end = vs_cur & ~vs_prev;
  assign copy      = frame_end_d & ~busy;
  assign oOverrun  = frame_end_d &  busy;

  always_comb begin
    hit       = '0;
    peak_next = '0;
    sum_next  = '0;
    for (int z = 0; z < ZONES; z++) begin
      hit[z]       = p_de && (p_zone != NO_ZONE) && (p_zone == 4'(z));
      peak_next[z] = frame_end_d ? '0 : peak_bank[z];
      sum_next[z]  = frame_end_d ? '0 : sum_bank[z];
      if (hit[z]) begin
        if (p_lum > peak_next[z]) peak_next[z] = p_lum;
        sum_next[z] = SUM_WIDTH'(sat_add(32'(sum_next[z]), 32'(p_lum), SUM_WIDTH));
      end
    end
  end

  always_ff @(posedge iODCK or negedge iRST_N) begin
    if (!iRST_N) begin
      peak_bank <= '0;
      sum_bank  <= '0;
    end else begin
      peak_bank <= peak_next;
      sum_bank  <= sum_next;
    end
  end

  // The readout captures the bank contents from before the clear, on the same edge.
  zone_readout #(
    .SUM_WIDTH (SUM_WIDTH)
  ) u_readout (
    .clk       (iODCK),
    .rst_n     (iRST_N),
    .start     (copy),
    .peak_bank (peak_bank),
    .sum_bank  (sum_bank),
    .ready     (iZone_Ready),
    .valid     (oZone_Valid),
    .index     (oZone_Index),
    .peak      (oZone_Peak),
    .sum       (oZone_Sum),
    .busy      (busy)
  );

  assign oBusy = busy;

endmodule

// File: tb/tb_zone_luma_stats.sv
// Directed bench for zone_luma_stats; the DUT is built with a 14-bit sum so
// saturation is reachable in a short run (2^(14-8)+10 pixels of 255).
module tb_zone_luma_stats;

  localparam int SW = 14;
  localparam logic [SW-1:0] SAT_MAX = '1;

  logic          iODCK = 1'b0;
  logic          iRST_N;
  logic          iVSYNC;
  logic          iDE;
  logic [7:0]    iR, iG, iB;
  logic [3:0]    iV_Address;
  logic          oZone_Valid;
  logic          iZone_Ready;
  logic [3:0]    oZone_Index;
  logic [7:0]    oZone_Peak;
  logic [SW-1:0] oZone_Sum;
  logic          oBusy;
  logic          oOverrun;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [3:0]    rec_idx  [0:15];
  logic [7:0]    rec_peak [0:15];
  logic [SW-1:0] rec_sum  [0:15];
  int            rec_cyc  [0:15];
  int            n_rec;
  int            stable_err;
  int            extra_vld;
  logic          post_vld;

  zone_luma_stats #(.SUM_WIDTH(SW)) dut (
    .iODCK       (iODCK),
    .iRST_N      (iRST_N),
    .iVSYNC      (iVSYNC),
    .iDE         (iDE),
    .iR          (iR),
    .iG          (iG),
    .iB          (iB),
    .iV_Address  (iV_Address),
    .oZone_Valid (oZone_Valid),
    .iZone_Ready (iZone_Ready),
    .oZone_Index (oZone_Index),
    .oZone_Peak  (oZone_Peak),
    .oZone_Sum   (oZone_Sum),
    .oBusy       (oBusy),
    .oOverrun    (oOverrun)
  );

  always #5 iODCK = ~iODCK;

  task automatic pix(input logic [3:0] z, input logic [7:0] r, input logic [7:0] g,
                     input logic [7:0] b);
    @(negedge iODCK);
    iDE = 1'b1; iV_Address = z; iR = r; iG = g; iB = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge iODCK);
      iDE = 1'b0; iV_Address = 4'd15; iR = 8'd0; iG = 8'd0; iB = 8'd0;
    end
  endtask

  task automatic vs_low();
    @(negedge iODCK);
    iDE = 1'b0; iVSYNC = 1'b0;
  endtask

  task automatic vs_rise();
    @(negedge iODCK);
    iDE = 1'b0; iVSYNC = 1'b1;
  endtask

  // Records up to n_exp transfers; cycle 0 is the first negedge after the call.
  // ready follows pat[cyc%4]. Afterwards samples one more cycle (post_vld) and
  // watches 20 cycles with ready high for any further record (extra_vld).
  task automatic collect(input logic [3:0] pat, input int n_exp);
    int         cyc;
    int         got;
    logic       held;
    logic [3:0] h_idx;
    logic [7:0] h_peak;
    logic [SW-1:0] h_sum;
    cyc = 0; got = 0; held = 1'b0; h_idx = '0; h_peak = '0; h_sum = '0;
    stable_err = 0; extra_vld = 0;
    while (got < n_exp && cyc < 200) begin
      @(negedge iODCK);
      if (held && (oZone_Valid !== 1'b1 || oZone_Index !== h_idx ||
                   oZone_Peak !== h_peak || oZone_Sum !== h_sum))
        stable_err++;
      iZone_Ready = pat[cyc % 4];
      if (oZone_Valid === 1'b1) begin
        if (iZone_Ready) begin
          rec_idx[got] = oZone_Index; rec_peak[got] = oZone_Peak;
          rec_sum[got] = oZone_Sum;   rec_cyc[got]  = cyc;
          got++;
          held = 1'b0;
        end else begin
          held = 1'b1; h_idx = oZone_Index; h_peak = oZone_Peak; h_sum = oZone_Sum;
        end
      end else begin
        held = 1'b0;
      end
      cyc++;
    end
    n_rec = got;
    @(negedge iODCK);
    post_vld = oZone_Valid;
    iZone_Ready = 1'b1;
    repeat (20) begin
      @(negedge iODCK);
      if (oZone_Valid !== 1'b0) extra_vld++;
    end
  endtask

  task automatic test_reset();
    iRST_N = 1'b0; iVSYNC = 1'b0; iDE = 1'b0; iR = 8'd0; iG = 8'd0; iB = 8'd0;
    iV_Address = 4'd15; iZone_Ready = 1'b0;
    #12;
    tests_run++;
    if ({oZone_Valid, oBusy, oOverrun} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: valid/busy/overrun=%b want 000", {oZone_Valid, oBusy, oOverrun});
    end
    tests_run++;
    if (oZone_Index !== 4'd0 || oZone_Peak !== 8'd0 || oZone_Sum !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: idx=%0d peak=%0d sum=%0d want 0/0/0", oZone_Index, oZone_Peak, oZone_Sum);
    end
    @(negedge iODCK);
    iRST_N = 1'b1;
    idle(4);
    tests_run++;
    if (oZone_Valid !== 1'b0 || oBusy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_quiet: valid=%b busy=%b want 0/0", oZone_Valid, oBusy);
    end
  endtask

  task automatic test_single_frame();
    int bad;
    vs_low();
    for (int l = 0; l < 72; l++) begin
      pix(4'd0, 8'd10, 8'd3, 8'd1);
      pix(4'd0, 8'd5, 8'd20, 8'd0);
      pix(4'd0, 8'd0, 8'd0, 8'd30);
      pix(4'd0, 8'd40, 8'd40, 8'd39);
    end
    idle(3);
    vs_rise();
    collect(4'b1111, 15);
    tests_run++;
    if (n_rec !== 15) begin
      tests_failed++; $display("FAIL single_count: got %0d records want 15", n_rec);
    end
    tests_run++;
    if (rec_cyc[0] !== 2 || rec_cyc[14] !== 16) begin
      tests_failed++;
      $display("FAIL single_timing: first/last at F+%0d/F+%0d want F+2/F+16", rec_cyc[0], rec_cyc[14]);
    end
    tests_run++;
    if (rec_idx[0] !== 4'd0 || rec_peak[0] !== 8'd40 || rec_sum[0] !== SW'(7200)) begin
      tests_failed++;
      $display("FAIL single_zone0: idx=%0d peak=%0d sum=%0d want 0/40/7200", rec_idx[0], rec_peak[0], rec_sum[0]);
    end
    bad = 0;
    for (int i = 1; i < 15; i++)
      if (rec_idx[i] !== 4'(i) || rec_peak[i] !== 8'd0 || rec_sum[i] !== '0) bad++;
    tests_run++;
    if (bad !== 0) begin
      tests_failed++; $display("FAIL single_others: %0d bad records want 0", bad);
    end
    tests_run++;
    if (post_vld !== 1'b0 || extra_vld !== 0) begin
      tests_failed++;
      $display("FAIL single_after: post_valid=%b extra=%0d want 0/0", post_vld, extra_vld);
    end
  endtask

  task automatic test_no_zone();
    int bad;
    vs_low();
    repeat (20) pix(4'd15, 8'd255, 8'd255, 8'd255);
    @(negedge iODCK);
    iDE = 1'b0; iV_Address = 4'd2; iR = 8'd255;
    idle(3);
    vs_rise();
    collect(4'b1111, 15);
    bad = 0;
    for (int i = 0; i < 15; i++)
      if (rec_peak[i] !== 8'd0 || rec_sum[i] !== '0) bad++;
    tests_run++;
    if (n_rec !== 15 || bad !== 0) begin
      tests_failed++;
      $display("FAIL no_zone: records=%0d nonzero=%0d want 15/0", n_rec, bad);
    end
  endtask

  task automatic test_saturation();
    vs_low();
    repeat (74) pix(4'd3, 8'd0, 8'd255, 8'd0);
    pix(4'd4, 8'd7, 8'd2, 8'd0);
    idle(3);
    vs_rise();
    collect(4'b1111, 15);
    tests_run++;
    if (rec_peak[3] !== 8'd255 || rec_sum[3] !== SAT_MAX) begin
      tests_failed++;
      $display("FAIL sat_zone3: peak=%0d sum=%0d want 255/%0d", rec_peak[3], rec_sum[3], SAT_MAX);
    end
    tests_run++;
    if (rec_peak[4] !== 8'd7 || rec_sum[4] !== SW'(7)) begin
      tests_failed++;
      $display("FAIL sat_zone4: peak=%0d sum=%0d want 7/7", rec_peak[4], rec_sum[4]);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    vs_low();
    for (int k = 0; k < 15; k++) begin
      logic [7:0] v;
      v = 8'(k * 10 + 1);
      case (k % 3)
        0:       pix(4'(k), v, v >> 1, 8'd0);
        1:       pix(4'(k), 8'd0, v, v >> 1);
        default: pix(4'(k), v >> 1, 8'd0, v);
      endcase
    end
    idle(3);
    vs_rise();
    collect(4'b1001, 15);
    tests_run++;
    if (n_rec !== 15 || extra_vld !== 0) begin
      tests_failed++;
      $display("FAIL bp_count: records=%0d extra=%0d want 15/0", n_rec, extra_vld);
    end
    tests_run++;
    if (stable_err !== 0) begin
      tests_failed++; $display("FAIL bp_stable: %0d changes while stalled want 0", stable_err);
    end
    bad = 0;
    for (int i = 0; i < 15; i++)
      if (rec_idx[i] !== 4'(i) || rec_peak[i] !== 8'(i * 10 + 1) || rec_sum[i] !== SW'(i * 10 + 1)) bad++;
    tests_run++;
    if (bad !== 0) begin
      tests_failed++; $display("FAIL bp_order: %0d records out of order or wrong want 0", bad);
    end
  endtask

  task automatic test_frame_boundary();
    vs_low();
    idle(2);
    @(negedge iODCK);
    iVSYNC = 1'b1; iDE = 1'b1; iV_Address = 4'd6; iR = 8'd60; iG = 8'd0; iB = 8'd0;
    @(negedge iODCK);
    iDE = 1'b1; iV_Address = 4'd6; iR = 8'd70;
    @(negedge iODCK);
    iDE = 1'b0;
    collect(4'b1111, 15);
    tests_run++;
    if (rec_peak[6] !== 8'd60 || rec_sum[6] !== SW'(60)) begin
      tests_failed++;
      $display("FAIL boundary_old: peak=%0d sum=%0d want 60/60", rec_peak[6], rec_sum[6]);
    end
    vs_low();
    idle(2);
    vs_rise();
    collect(4'b1111, 15);
    tests_run++;
    if (rec_peak[6] !== 8'd70 || rec_sum[6] !== SW'(70)) begin
      tests_failed++;
      $display("FAIL boundary_new: peak=%0d sum=%0d want 70/70", rec_peak[6], rec_sum[6]);
    end
  endtask

  task automatic test_overrun();
    logic found;
    int   bad;
    vs_low();
    pix(4'd1, 8'd11, 8'd0, 8'd0);
    pix(4'd5, 8'd0, 8'd55, 8'd0);
    idle(3);
    vs_rise();
    iZone_Ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge iODCK);
      if (oZone_Valid === 1'b1 && oZone_Index === 4'd5) begin
        iZone_Ready = 1'b0; found = 1'b1;
      end else begin
        iZone_Ready = 1'b1;
      end
    end
    tests_run++;
    if (found !== 1'b1) begin
      tests_failed++; $display("FAIL ovr_pending: zone 5 pending=%b want 1", found);
    end
    pix(4'd5, 8'd99, 8'd0, 8'd0);
    idle(1);
    vs_low();
    vs_rise();
    @(negedge iODCK);
    tests_run++;
    if (oOverrun !== 1'b0) begin
      tests_failed++; $display("FAIL ovr_early: overrun=%b in F want 0", oOverrun);
    end
    @(negedge iODCK);
    tests_run++;
    if (oOverrun !== 1'b1) begin
      tests_failed++; $display("FAIL ovr_pulse: overrun=%b in F+1 want 1", oOverrun);
    end
    @(negedge iODCK);
    tests_run++;
    if (oOverrun !== 1'b0 || oZone_Valid !== 1'b1 || oZone_Index !== 4'd5) begin
      tests_failed++;
      $display("FAIL ovr_after: overrun=%b valid=%b idx=%0d want 0/1/5", oOverrun, oZone_Valid, oZone_Index);
    end
    collect(4'b1111, 10);
    bad = 0;
    for (int i = 0; i < 10; i++)
      if (rec_idx[i] !== 4'(i + 5)) bad++;
    tests_run++;
    if (n_rec !== 10 || bad !== 0 || rec_peak[0] !== 8'd55 || rec_sum[0] !== SW'(55)) begin
      tests_failed++;
      $display("FAIL ovr_rest: records=%0d misordered=%0d zone5=%0d/%0d want 10/0/55/55",
               n_rec, bad, rec_peak[0], rec_sum[0]);
    end
    tests_run++;
    if (extra_vld !== 0) begin
      tests_failed++; $display("FAIL ovr_dropped: %0d extra valid cycles want 0", extra_vld);
    end
  endtask

  task automatic test_async_reset();
    logic found;
    int   bad;
    vs_low();
    pix(4'd7, 8'd77, 8'd0, 8'd0);
    pix(4'd2, 8'd0, 8'd22, 8'd0);
    idle(3);
    vs_rise();
    iZone_Ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge iODCK);
      if (oZone_Valid === 1'b1 && oZone_Index === 4'd7) begin
        iZone_Ready = 1'b0; found = 1'b1;
      end else begin
        iZone_Ready = 1'b1;
      end
    end
    tests_run++;
    if (found !== 1'b1) begin
      tests_failed++; $display("FAIL arst_pending: zone 7 pending=%b want 1", found);
    end
    pix(4'd7, 8'd50, 8'd0, 8'd0);
    idle(2);
    #2 iRST_N = 1'b0;
    #1;
    tests_run++;
    if ({oZone_Valid, oBusy, oOverrun} !== 3'b000 || oZone_Index !== 4'd0 ||
        oZone_Peak !== 8'd0 || oZone_Sum !== '0) begin
      tests_failed++;
      $display("FAIL arst_outputs: valid=%b busy=%b ovr=%b idx=%0d peak=%0d sum=%0d want all 0",
               oZone_Valid, oBusy, oOverrun, oZone_Index, oZone_Peak, oZone_Sum);
    end
    iVSYNC = 1'b0;
    iZone_Ready = 1'b1;
    @(negedge iODCK);
    @(negedge iODCK);
    iRST_N = 1'b1;
    idle(2);
    pix(4'd4, 8'd0, 8'd0, 8'd44);
    idle(3);
    vs_rise();
    collect(4'b1111, 15);
    tests_run++;
    if (n_rec !== 15 || rec_idx[0] !== 4'd0) begin
      tests_failed++;
      $display("FAIL arst_restart: records=%0d first idx=%0d want 15/0", n_rec, rec_idx[0]);
    end
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (i == 4) begin
        if (rec_peak[i] !== 8'd44 || rec_sum[i] !== SW'(44)) bad++;
      end else if (rec_peak[i] !== 8'd0 || rec_sum[i] !== '0) begin
        bad++;
      end
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++; $display("FAIL arst_fresh: %0d stale or wrong records want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_no_zone();
    test_saturation();
    test_backpressure();
    test_frame_boundary();
    test_overrun();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
